// File: rtl/demosaic_pkg.sv
// Shared constants and FSM encoding for the demosaic frame-memory read-back path.
package demosaic_pkg;
  localparam int IMG_W      = 128;
  localparam int IMG_H      = 128;
  localparam int ADDR_W     = 14;
  localparam int COL_W      = 7;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 14'd16383;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/pix_sync_fifo.sv
// Small synchronous FIFO holding pixel words plus frame/line markers.
module pix_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH+1))'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: storage has no reset; only pointers and count do, and the head is never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/rgb_frame_streamer.sv
// Reads the R/G/B planes in raster order and streams {R,G,B} pixels with sof/eol/eof
// markers; reads are credit-limited so the output FIFO can never overflow.
module rgb_frame_streamer
  import demosaic_pkg::*;
#(
  parameter int ADDR_W     = demosaic_pkg::ADDR_W,
  parameter int COL_W      = demosaic_pkg::COL_W,
  parameter int DATA_W     = demosaic_pkg::DATA_W,
  parameter int FIFO_DEPTH = demosaic_pkg::FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   rdata_r,
  input  logic [DATA_W-1:0]   rdata_g,
  input  logic [DATA_W-1:0]   rdata_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3*DATA_W-1:0] out_pixel,
  output logic                out_sof,
  output logic                out_eol,
  output logic                out_eof,
  output logic                busy,
  output logic                done
);
  localparam int WORD_W = 3 * DATA_W + 3;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] FINAL_ADDR = '1;

  state_t              state, next_state;
  logic                issue, first_issue, busy_nxt, done_set, done_clr;
  logic                rd_en_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic [1:0]          inflight;
  logic [CNT_W:0]      credit_used;
  logic                credit_ok;
  logic [WORD_W-1:0]   push_word, head_word;

  // Reads on the bus this cycle plus reads whose data is being captured at this edge.
  assign inflight    = {1'b0, rd_en} + {1'b0, rd_en_d};
  assign credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start) next_state = ST_STREAM;
      ST_STREAM: if (credit_ok && addr == FINAL_ADDR - 1'b1) next_state = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty && inflight == 2'd0) next_state = ST_FINISH;
      ST_FINISH: next_state = ST_IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    issue       = 1'b0;
    first_issue = 1'b0;
    done_set    = (state == ST_FINISH);
    done_clr    = 1'b0;
    busy_nxt    = (next_state == ST_STREAM) || (next_state == ST_DRAIN);
    unique case (state)
      ST_IDLE: if (start) begin
        issue       = 1'b1;
        first_issue = 1'b1;
        done_clr    = 1'b1;
      end
      ST_STREAM: issue = credit_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en   <= 1'b0;
      addr    <= '0;
      rd_en_d <= 1'b0;
      addr_d  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_en   <= issue;
      if (first_issue) addr <= '0;
      else if (issue)  addr <= addr + 1'b1;
      rd_en_d <= rd_en;
      addr_d  <= addr;
      busy    <= busy_nxt;
      if (done_clr)      done <= 1'b0;
      else if (done_set) done <= 1'b1;
    end
  end

  // Markers are decoded from the address whose data is arriving this cycle.
  assign push_word = {rdata_r, rdata_g, rdata_b,
                      addr_d == '0,
                      &addr_d[COL_W-1:0],
                      addr_d == FINAL_ADDR};

  pix_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_en_d),
    .push_data (push_word),
    .pop       (out_valid & out_ready),
    .pop_data  (head_word),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign {out_pixel, out_sof, out_eol, out_eof} = out_valid ? head_word : '0;
endmodule
